xversat_dbus_arb: RTL and testbench

//  Parametrised Versat top-level control and databus arbiter.
//  - Decodes CPU run/clear accesses and generates single-cycle run/clear pulses to N_FU functional units.
//  - Aggregates FU done flags and keeps a run-cycle counter.
//  - Merges N_CH FU databus channels onto one external burst databus with round-robin, burst-locked arbitration.
//  - Replaces the fixed 3-port databus and the valid-based dma_len mux.

---
 rtl/xversat_dbus_arb.sv | 170 +++++++++++++++++
 tb/tb_xversat_dbus_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xversat_dbus_arb.sv
// Versat top-level control (run/clear pulses, done/cycle status) and N_CH-to-1 burst databus arbiter.
// Define XVERSAT_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module xversat_dbus_arb #(
    parameter int ADDR_W    = 32,
    parameter int IO_ADDR_W = 32,
    parameter int DATABUS_W = 256,
    parameter int AXI_LEN_W = 8,
    parameter int N_CH      = 3,
    parameter int N_FU      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          wstrb,
    input  logic [IO_ADDR_W-1:0]          wdata,
    output logic                          ready,
    output logic [IO_ADDR_W-1:0]          rdata,
    output logic                          fu_run,
    output logic                          fu_clear,
    input  logic [N_FU-1:0]               fu_done,
    input  logic [N_CH-1:0]               ch_valid,
    input  logic [N_CH*IO_ADDR_W-1:0]     ch_addr,
    input  logic [N_CH*DATABUS_W-1:0]     ch_wdata,
    input  logic [N_CH*DATABUS_W/8-1:0]   ch_wstrb,
    input  logic [N_CH*AXI_LEN_W-1:0]     ch_len,
    output logic [N_CH-1:0]               ch_ready,
    output logic [N_CH*DATABUS_W-1:0]     ch_rdata,
    output logic                          m_valid,
    output logic [IO_ADDR_W-1:0]          m_addr,
    output logic [DATABUS_W-1:0]          m_wdata,
    output logic [DATABUS_W/8-1:0]        m_wstrb,
    output logic [AXI_LEN_W-1:0]          m_len,
    input  logic                          m_ready,
    input  logic [DATABUS_W-1:0]          m_rdata
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = IO_ADDR_W - 2;
    localparam int SW = DATABUS_W / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [GW-1:0]        grant, grant_n, pick;
    logic                 pick_ok;
    logic [AXI_LEN_W-1:0] len_r, len_n, beat, beat_n;
    logic [CW-1:0]        cycles;
    logic                 rc, rc_d, done, idle, fire;
    logic                 unused_inputs;
`ifndef XVERSAT_FIXED_PRIO_EN
    logic [GW-1:0]        last_grant, last_grant_n;
`endif

    assign rc            = valid & addr[ADDR_W-1];
    assign done          = &fu_done;
    assign idle          = (state == IDLE) & ~|ch_valid;
    assign ready         = 1'b1;
    assign rdata         = {cycles, idle, done};
    assign m_len         = len_r;
    assign ch_rdata      = {N_CH{m_rdata}};
    assign fire          = m_valid & m_ready;
    assign unused_inputs = ^{wdata, wstrb, addr[ADDR_W-3:0]};

    // Pulses fire only on the rising edge of a run/clear access, so a held valid pulses once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rc_d     <= 1'b0;
            fu_run   <= 1'b0;
            fu_clear <= 1'b0;
            cycles   <= '0;
        end else begin
            rc_d     <= rc;
            fu_run   <= rc & ~rc_d & ~addr[ADDR_W-2];
            fu_clear <= rc & ~rc_d & addr[ADDR_W-2];
            if (fu_run)
                cycles <= '0;
            else if (!done && !(&cycles))
                cycles <= cycles + 1'b1;
        end
    end

    // Lowest requester wins by default; in round-robin a requester above last_grant overrides it.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                pick    = GW'(i);
                pick_ok = 1'b1;
            end
        end
`ifndef XVERSAT_FIXED_PRIO_EN
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_valid[i] && (GW'(i) > last_grant))
                pick = GW'(i);
        end
`endif
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        len_n   = len_r;
        beat_n  = beat;
`ifndef XVERSAT_FIXED_PRIO_EN
        last_grant_n = last_grant;
`endif
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_n = BURST;
                    grant_n = pick;
                    len_n   = ch_len[int'(pick)*AXI_LEN_W +: AXI_LEN_W];
                    beat_n  = '0;
                end
            end
            BURST: begin
                if (fire) begin
                    if (beat == len_r) begin
                        state_n = IDLE;
`ifndef XVERSAT_FIXED_PRIO_EN
                        last_grant_n = grant;
`endif
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            len_r <= '0;
            beat  <= '0;
`ifndef XVERSAT_FIXED_PRIO_EN
            last_grant <= GW'(N_CH - 1);
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            len_r <= len_n;
            beat  <= beat_n;
`ifndef XVERSAT_FIXED_PRIO_EN
            last_grant <= last_grant_n;
`endif
        end
    end

    // A granted channel that drops valid simply stalls its burst; the grant is kept.
    always_comb begin
        m_valid  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        ch_ready = '0;
        if (state == BURST) begin
            m_valid         = ch_valid[grant];
            m_addr          = ch_addr[int'(grant)*IO_ADDR_W +: IO_ADDR_W];
            m_wdata         = ch_wdata[int'(grant)*DATABUS_W +: DATABUS_W];
            m_wstrb         = ch_wstrb[int'(grant)*SW +: SW];
            ch_ready[grant] = m_ready;
        end
    end

endmodule

// File: tb/tb_xversat_dbus_arb.sv
// Directed and random checks of xversat_dbus_arb against a transaction-level model of arbitration and status.
module tb_xversat_dbus_arb;

    localparam int AW = 32, IW = 32, DW = 64, LW = 8, NC = 3, NF = 2, SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst, valid, wstrb, ready, fu_run, fu_clear;
    logic [AW-1:0]     addr;
    logic [IW-1:0]     wdata, rdata, m_addr;
    logic [NF-1:0]     fu_done;
    logic [NC-1:0]     ch_valid, ch_ready;
    logic [NC*IW-1:0]  ch_addr;
    logic [NC*DW-1:0]  ch_wdata, ch_rdata;
    logic [NC*SW-1:0]  ch_wstrb;
    logic [NC*LW-1:0]  ch_len;
    logic              m_valid, m_ready;
    logic [DW-1:0]     m_wdata, m_rdata;
    logic [SW-1:0]     m_wstrb;
    logic [LW-1:0]     m_len;

    int checks = 0, passes = 0, fails = 0;

    // Model: who owns the bus, how many beats it has delivered, and who was served last.
    bit          busy;
    int          owner, served, blen, last_ch;
    logic [29:0] exp_cycles;
    bit          exp_run, exp_clear, prev_rc;

    logic [NC-1:0] obs_ready;
    logic          obs_mvalid, obs_run;
    logic [IW-1:0] obs_rdata;

    xversat_dbus_arb #(.ADDR_W(AW), .IO_ADDR_W(IW), .DATABUS_W(DW), .AXI_LEN_W(LW),
                       .N_CH(NC), .N_FU(NF)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .ready(ready), .rdata(rdata), .fu_run(fu_run), .fu_clear(fu_clear), .fu_done(fu_done),
        .ch_valid(ch_valid), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_len(ch_len), .ch_ready(ch_ready), .ch_rdata(ch_rdata), .m_valid(m_valid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_len(m_len),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_next(input logic [NC-1:0] v, input int last);
`ifdef XVERSAT_FIXED_PRIO_EN
        for (int i = 0; i < NC; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NC; k++) if (v[(last + k) % NC]) return (last + k) % NC;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        busy = 0; owner = 0; served = 0; blen = 0; last_ch = NC - 1;
        exp_cycles = '0; exp_run = 0; exp_clear = 0; prev_rc = 0;
    endtask

    // One clock: randomise payloads, check outputs against the model, advance the model, clock.
    task automatic step();
        logic [NC-1:0] exp_rdy;
        logic          exp_mv, rc;
        ch_addr  = {$urandom, $urandom, $urandom};
        ch_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ch_wstrb = 24'($urandom);
        m_rdata  = {$urandom, $urandom};
        wdata    = $urandom;
        wstrb    = 1'($urandom);
        addr[29:0] = 30'($urandom);
        #1;
        exp_mv  = busy && ch_valid[owner];
        exp_rdy = '0;
        if (busy && m_ready) exp_rdy[owner] = 1'b1;
        obs_ready = ch_ready; obs_mvalid = m_valid; obs_run = fu_run; obs_rdata = rdata;
        checkOutput("rdata", rdata, {exp_cycles, (!busy && ch_valid == '0), &fu_done});
        checkOutput("fu_run", fu_run, exp_run);
        checkOutput("fu_clear", fu_clear, exp_clear);
        checkOutput("ready", ready, 1'b1);
        checkOutput("m_valid", m_valid, exp_mv);
        checkOutput("ch_ready", ch_ready, exp_rdy);
        for (int i = 0; i < NC; i++) checkOutput("ch_rdata", ch_rdata[i*DW +: DW], m_rdata);
        if (busy) checkOutput("m_len", m_len, blen);
        if (exp_mv) begin
            checkOutput("m_addr", m_addr, ch_addr[owner*IW +: IW]);
            checkOutput("m_wdata", m_wdata, ch_wdata[owner*DW +: DW]);
            checkOutput("m_wstrb", m_wstrb, ch_wstrb[owner*SW +: SW]);
        end
        if (!rst) begin
            model_reset();
        end else begin
            rc = valid & addr[31];
            if (exp_run) exp_cycles = '0;
            else if (!(&fu_done) && exp_cycles != {30{1'b1}}) exp_cycles = exp_cycles + 1'b1;
            exp_run   = rc && !prev_rc && !addr[30];
            exp_clear = rc && !prev_rc && addr[30];
            prev_rc   = rc;
            if (!busy) begin
                if (ch_valid != '0) begin
                    owner = pick_next(ch_valid, last_ch);
                    blen = int'(ch_len[owner*LW +: LW]);
                    served = 0;
                    busy = 1;
                end
            end else if (ch_valid[owner] && m_ready) begin
                if (served == blen) begin busy = 0; last_ch = owner; end
                else served++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic a31, input logic a30,
                                 input logic [1:0] d, input logic [2:0] cv,
                                 input logic [23:0] len, input logic mr);
        rst = r; valid = v; addr[31] = a31; addr[30] = a30;
        fu_done = d; ch_valid = cv; ch_len = len; m_ready = mr;
        step();
    endtask

    initial begin
        int run_cnt, beats, b1, c0, drop;
        int g[$];
        int exp_order[4] = '{0, 1, 2, 0};
        logic [NC-1:0] prev_r;

        rst = 0; valid = 0; addr = '0; wstrb = 0; wdata = '0; fu_done = '0;
        ch_valid = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0; ch_len = '0;
        m_ready = 0; m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        $display("[TB] reset release");
        applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 24'h0, 0);
        checkOutput("reset_idle_bit", obs_rdata[1], 1'b1);

        $display("[TB] held run write");
        run_cnt = 0;
        repeat (4) begin applyStimulus(1, 1, 1, 0, 2'b00, 3'b000, 24'h0, 0); run_cnt += obs_run; end
        repeat (3) begin applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 24'h0, 0); run_cnt += obs_run; end
        checkOutput("run_pulse_count", run_cnt, 1);
        repeat (4) applyStimulus(1, 0, 0, 0, 2'b11, 3'b000, 24'h0, 0);

        $display("[TB] three requesters, len 3");
        beats = 0; prev_r = '0;
        repeat (17) begin
            applyStimulus(1, 0, 0, 0, 2'b11, 3'b111, {8'd3, 8'd3, 8'd3}, 1);
            if (obs_ready != '0) beats++;
            if (obs_ready != '0 && prev_r == '0)
                for (int i = 0; i < NC; i++) if (obs_ready[i]) g.push_back(i);
            prev_r = obs_ready;
        end
        checkOutput("rr_beats", beats, 13);
        checkOutput("rr_bursts", g.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("rr_order", (i < g.size()) ? g[i] : -1, exp_order[i]);

        $display("[TB] stalled ch1 burst");
        applyStimulus(0, 0, 0, 0, 2'b11, 3'b000, 24'h0, 1);
        applyStimulus(1, 0, 0, 0, 2'b11, 3'b010, {8'd0, 8'd7, 8'd0}, 1);
        b1 = 0; c0 = 0; drop = 0;
        repeat (3) begin
            applyStimulus(1, 0, 0, 0, 2'b11, 3'b011, {8'd0, 8'd7, 8'd0}, 1);
            b1 += obs_ready[1]; c0 += obs_ready[0];
        end
        repeat (2) begin
            applyStimulus(1, 0, 0, 0, 2'b11, 3'b001, {8'd0, 8'd7, 8'd0}, 1);
            drop += obs_mvalid; c0 += obs_ready[0];
        end
        repeat (5) begin
            applyStimulus(1, 0, 0, 0, 2'b11, 3'b011, {8'd0, 8'd2, 8'd0}, 1);
            b1 += obs_ready[1]; c0 += obs_ready[0];
        end
        checkOutput("stall_ch1_beats", b1, 8);
        checkOutput("stall_ch0_ready", c0, 0);
        checkOutput("stall_m_valid", drop, 0);

        $display("[TB] reset during ch2 burst");
        repeat (3) applyStimulus(1, 0, 0, 0, 2'b11, 3'b100, {8'd3, 8'd0, 8'd0}, 1);
        applyStimulus(0, 0, 0, 0, 2'b11, 3'b100, {8'd3, 8'd0, 8'd0}, 1);
        applyStimulus(1, 0, 0, 0, 2'b11, 3'b101, {8'd1, 8'd1, 8'd1}, 1);
        checkOutput("post_reset_m_valid", obs_mvalid, 1'b0);
        applyStimulus(1, 0, 0, 0, 2'b11, 3'b101, {8'd1, 8'd1, 8'd1}, 1);
        checkOutput("post_reset_grant", obs_ready, 3'b001);

        $display("[TB] random traffic");
        repeat (400) begin
            applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom),
                          3'($urandom),
                          {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)},
                          ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
